// File: rtl/mcs4_clock_sequencer.sv
// Clock-phase controller for the 4004 core: two-phase clocks, power-on clear, subcycle
// tracking with sync re-alignment, and run/halt/single-step sequencing from one clock.
module mcs4_clock_sequencer #(
  parameter int unsigned SLOT_LEN   = 2,
  parameter int unsigned POC_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step_req,
  input  logic        poc_req,
  input  logic        sync_in,
  output logic        clk1,
  output logic        clk2,
  output logic        poc,
  output logic [7:0]  phase,
  output logic        halted,
  output logic        step_ack,
  output logic        sync_err,
  output logic [15:0] cycle_cnt
);

  localparam int unsigned TW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int unsigned PW = $clog2(POC_CYCLES + 1);
  localparam logic [TW-1:0] TLast = TW'(SLOT_LEN - 1);
  localparam logic [PW-1:0] PLast = PW'(POC_CYCLES - 1);

  typedef enum logic [1:0] {StPoc, StRun, StHalt, StStep} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [1:0]    s_q, s_d;
  logic [2:0]    p_q, p_d;
  logic [PW-1:0] poc_cnt_q, poc_cnt_d;
  logic          step_prev_q, step_pend_q, step_pend_d;
  logic          poc_pend_q, poc_pend_d;

  logic running, sub_end, sync_hit, bnd, bad_sync, enter_poc, cnt_inc;

  // Counters always point at the position the outputs will show after the next edge.
  always_comb begin
    running   = (state_q != StHalt);
    sub_end   = running && (t_q == TLast) && (s_q == 2'd3);
    sync_hit  = sub_end && sync_in && ((state_q == StRun) || (state_q == StStep));
    bnd       = sub_end && ((p_q == 3'd7) || sync_hit);
    bad_sync  = sync_hit && (p_q != 3'd7);
    cnt_inc   = bnd && ((state_q == StRun) || (state_q == StStep));

    state_d = state_q;
    unique case (state_q)
      StPoc:  if (bnd && (poc_cnt_q == PLast)) state_d = run ? StRun : StHalt;
      StRun:  if (bnd) begin
                if (poc_pend_q)  state_d = StPoc;
                else if (!run)   state_d = StHalt;
              end
      StHalt: if (poc_pend_q)       state_d = StPoc;
              else if (run)         state_d = StRun;
              else if (step_pend_q) state_d = StStep;
      StStep: if (bnd) state_d = poc_pend_q ? StPoc : StHalt;
      default: state_d = StPoc;
    endcase

    enter_poc = (state_d == StPoc) && (state_q != StPoc);

    poc_pend_d = enter_poc ? 1'b0 : (poc_pend_q | poc_req);
    if (enter_poc || ((state_q == StHalt) && (state_d == StStep))) step_pend_d = 1'b0;
    else step_pend_d = step_pend_q | (step_req & ~step_prev_q);

    poc_cnt_d = poc_cnt_q;
    if (enter_poc) poc_cnt_d = '0;
    else if ((state_q == StPoc) && bnd) poc_cnt_d = poc_cnt_q + PW'(1);

    t_d = t_q;
    s_d = s_q;
    p_d = p_q;
    if (!running) begin
      t_d = '0;
      s_d = '0;
      p_d = '0;
    end else if (t_q != TLast) begin
      t_d = t_q + TW'(1);
    end else begin
      t_d = '0;
      s_d = s_q + 2'd1;
      if (s_q == 2'd3) p_d = sync_hit ? 3'd0 : p_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPoc;
      t_q         <= '0;
      s_q         <= '0;
      p_q         <= '0;
      poc_cnt_q   <= '0;
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
      poc_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      s_q         <= s_d;
      p_q         <= p_d;
      poc_cnt_q   <= poc_cnt_d;
      step_prev_q <= step_req;
      step_pend_q <= step_pend_d;
      poc_pend_q  <= poc_pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk1      <= 1'b0;
      clk2      <= 1'b0;
      poc       <= 1'b1;
      phase     <= 8'h01;
      halted    <= 1'b0;
      step_ack  <= 1'b0;
      sync_err  <= 1'b0;
      cycle_cnt <= 16'h0000;
    end else begin
      clk1     <= running && (s_q == 2'd0);
      clk2     <= running && (s_q == 2'd2);
      poc      <= (state_q == StPoc);
      phase    <= running ? (8'h01 << p_q) : 8'h01;
      halted   <= (state_d == StHalt);
      step_ack <= (state_q == StStep) && bnd;
      sync_err <= bad_sync;
      if (cnt_inc) cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mcs4_clock_sequencer.sv
// Scoreboard bench for mcs4_clock_sequencer (SLOT_LEN=2, POC_CYCLES=2): expectations are
// queued as stimulus is applied and compared when the matching DUT output is sampled.
module tb_mcs4_clock_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, step_req, poc_req, sync_in;
  logic        clk1, clk2, poc, halted, step_ack, sync_err;
  logic [7:0]  phase;
  logic [15:0] cycle_cnt;

  mcs4_clock_sequencer #(.SLOT_LEN(2), .POC_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .step_req (step_req),
    .poc_req  (poc_req),
    .sync_in  (sync_in),
    .clk1     (clk1),
    .clk2     (clk2),
    .poc      (poc),
    .phase    (phase),
    .halted   (halted),
    .step_ack (step_ack),
    .sync_err (sync_err),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", obs, 32'hDEAD_BEEF);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  function automatic int rel();
    return cyc - base;
  endfunction

  task automatic goto(input int n);
    while (rel() < n) @(negedge clk);
  endtask

  function automatic logic [31:0] pack_all();
    return {2'b00, poc, clk1, clk2, phase, halted, step_ack, sync_err, cycle_cnt};
  endfunction

  localparam logic [31:0] RstVec = {2'b00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0};

  int k, sub, acks, clk1_pulses, ack_at, poc_hi, sync_pulses;
  logic prev_clk1;

  initial begin
    rst_n = 1'b0; run = 1'b1; step_req = 1'b0; poc_req = 1'b0; sync_in = 1'b0;
    repeat (2) @(negedge clk);
    push("reset_outputs", RstVec);
    observe(pack_all());
    rst_n = 1'b1;
    base = cyc;

    // Reset and POC waveform, then the first subcycle of RUN.
    for (int n = 1; n <= 136; n++) begin
      goto(n);
      k = (n - 1) % 8;
      sub = ((n - 1) / 8) % 8;
      push($sformatf("wave@%0d", n),
           {21'd0, (n <= 128), (k < 2), (k == 4 || k == 5), 8'(8'h01 << sub)});
      observe({21'd0, poc, clk1, clk2, phase});
    end

    // Halt at boundary: drop run in the middle of M1 of the first RUN cycle.
    goto(156); run = 1'b0;
    goto(191); push("halted_before_x3_end", 0); observe(halted);
    goto(192); push("halted_at_boundary", 1); observe(halted);
    push("cnt_after_halt", 1); observe(cycle_cnt);
    for (int n = 193; n <= 200; n++) begin
      goto(n);
      push($sformatf("halt_idle@%0d", n), {22'd0, 2'b00, 8'h01});
      observe({22'd0, clk1, clk2, phase});
    end

    // Single step: step_req high for 3 clocks starting at rel 200.
    step_req = 1'b1;
    push("step_ack_latency", 66);
    push("step_ack_count", 1);
    push("step_clk1_pulses", 8);
    push("step_halted_after", 1);
    push("step_cnt", 2);
    acks = 0; clk1_pulses = 0; ack_at = -1; prev_clk1 = 1'b0;
    while (rel() < 400) begin
      @(negedge clk);
      if (rel() == 203) step_req = 1'b0;
      if (step_ack) begin
        acks++;
        if (ack_at < 0) ack_at = rel() - 200;
      end
      if (clk1 && !prev_clk1) clk1_pulses++;
      prev_clk1 = clk1;
    end
    observe(ack_at);
    observe(acks);
    observe(clk1_pulses);
    observe(halted);
    observe(cycle_cnt);

    // Sync re-alignment: resume RUN, force sync at the end of M2.
    run = 1'b1;
    goto(440); sync_in = 1'b1;
    push("sync_err_before", 0); observe(sync_err);
    goto(441); sync_in = 1'b0;
    push("sync_err_pulse", 1); observe(sync_err);
    push("phase_at_m2_end", 32'h10); observe(phase);
    push("cnt_after_sync", 3); observe(cycle_cnt);
    goto(442);
    push("phase_after_sync", 32'h01); observe(phase);
    push("sync_err_after", 0); observe(sync_err);
    run = 1'b0;

    // Halt again, bounded wait.
    push("halt2_cycle", 505);
    while (!halted && rel() < 600) @(negedge clk);
    observe(rel());

    // Simultaneous poc_req and step edge while halted.
    goto(510); poc_req = 1'b1; step_req = 1'b1;
    goto(511); poc_req = 1'b0;
    push("poc_high_clocks", 128);
    push("sim_step_acks", 0);
    push("sim_halted_end", 1);
    push("cnt_kept_by_poc", 4);
    poc_hi = 0; acks = 0;
    while (rel() < 800) begin
      @(negedge clk);
      if (poc) poc_hi++;
      if (step_ack) acks++;
    end
    observe(poc_hi);
    observe(acks);
    observe(halted);
    observe(cycle_cnt);
    step_req = 1'b0;

    // Counter wrap from a preloaded 0xFFFF.
    run = 1'b1;
    goto(810); force dut.cycle_cnt = 16'hFFFF;
    goto(811); release dut.cycle_cnt;
    goto(864); push("cnt_preloaded", 32'hFFFF); observe(cycle_cnt);
    goto(865); push("cnt_wrapped", 0); observe(cycle_cnt);

    // Asynchronous reset while clk2 is high.
    push("clk2_seen_high", 1);
    while (!clk2 && rel() < 1000) @(negedge clk);
    observe(clk2);
    #2 rst_n = 1'b0;
    #1;
    push("async_clk2_low", 0); observe(clk2);
    push("async_reset_outputs", RstVec); observe(pack_all());

    sync_pulses = sb.size();
    if (sync_pulses != 0) check_eq("scoreboard_leftover", sync_pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcs4_clock_sequencer.md
# mcs4_clock_sequencer

Clock-phase controller for the on-chip 4004 core. It derives the non-overlapping two-phase clocks `clk1`/`clk2` and the power-on-clear `poc` from the single system clock. It tracks the eight-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3), re-aligning to the core's `sync`. It also provides run/halt/single-step control of the core, so these signals no longer have to be driven from input pads.

## Interface

Parameters:
- `SLOT_LEN`, default 2: system clocks per clock slot; legal range is 1 or more.
- `POC_CYCLES`, default 8: full instruction cycles for which `poc` is held after reset or `poc_req`; legal range is 1 or more.

Ports:
- `clk` in 1: system clock. Everything is clocked on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: level. 1 means free-run; 0 means halt at the next instruction boundary.
- `step_req` in 1: level. A rising edge requests one instruction cycle while halted.
- `poc_req` in 1: one-cycle pulse. Re-enter POC at the next instruction boundary.
- `sync_in` in 1: `sync` from the core.
- `clk1` out 1: phase-1 clock to the core.
- `clk2` out 1: phase-2 clock to the core.
- `poc` out 1: power-on clear to the core.
- `phase` out 8: one-hot subcycle. Bit 0 is A1 and bit 7 is X3.
- `halted` out 1: 1 while in HALT.
- `step_ack` out 1: one-cycle pulse when a stepped cycle completes.
- `sync_err` out 1: one-cycle pulse on a sync mis-alignment.
- `cycle_cnt` out 16: count of completed non-POC instruction cycles.

## Operation

- **Counters.**
  - Slot tick `t` runs 0..SLOT_LEN-1.
  - Slot `s` runs 0..3.
  - Subcycle `p` runs 0..7.
  - One subcycle is 4·SLOT_LEN clocks. One instruction cycle is 32·SLOT_LEN clocks.
- **Clock outputs.** Both are registered.
  - `clk1` is 1 during slot 0.
  - `clk2` is 1 during slot 2.
  - Slots 1 and 3 are gaps. `clk1` and `clk2` are never high together.
- **Boundary.** The last tick of slot 3 is the subcycle end. The instruction boundary is the subcycle end of X3, or a sync-forced re-alignment.
- **States:** POC, RUN, HALT, STEP.
  - **POC.** Clocks run and `poc`=1. After POC_CYCLES boundaries:
    - `poc` goes to 0 at that boundary.
    - Go to RUN if `run`=1, otherwise HALT.
  - **RUN.** Clocks run. At each boundary:
    - A pending `poc_req` takes the block to POC.
    - Otherwise `run`=0 takes it to HALT.
    - Otherwise it stays in RUN.
  - **HALT.**
    - `clk1`=`clk2`=0, `phase`=A1, and counters are held at 0.
    - A pending `poc_req` takes the block to POC.
    - Otherwise `run`=1 takes it to RUN.
    - Otherwise a pending step takes it to STEP. The step latch is cleared on entry.
  - **STEP.** Clocks run for one instruction cycle. At the boundary:
    - Pulse `step_ack`.
    - Increment `cycle_cnt`.
    - A pending `poc_req` takes the block to POC; otherwise go to HALT.
- **Request latches.**
  - `step_req` is edge-detected into a step-pending latch.
  - `poc_req` sets a poc-pending latch.
  - Both latches persist until consumed. Both are cleared on entry to POC.
- **Sync.**
  - `sync_in` is sampled at every subcycle end, in RUN and STEP only.
  - If it is 1, the next subcycle is A1.
  - If `p` is not X3 at that point, `sync_err` pulses and the event counts as a boundary.
  - If `sync_in` is 0 at X3, the block free-runs to A1 with no error.
  - `sync_in` is ignored in POC and HALT.
- **`cycle_cnt`.** Increments at every boundary leaving RUN or STEP. It wraps from 0xFFFF to 0 and is not cleared by POC.
- **Simultaneous events at a boundary.** Priority is poc-pending, then `run`, then step.

## Timing

- **Reset values, while `rst_n`=0:**
  - state POC, `poc`=1, `clk1`=0, `clk2`=0, `phase`=0x01;
  - `halted`=0, `step_ack`=0, `sync_err`=0, `cycle_cnt`=0;
  - latches cleared, counters 0.
- **First clock after reset.** `clk1` rises on the first `clk` edge after `rst_n` deasserts, at `t`=0, `s`=0.
- **Reset mid-operation.** All outputs go to their reset values asynchronously.
- **Output registration.** All outputs are registered.
  - `phase` changes on the same edge that starts slot 0 of the new subcycle.
  - `poc` deasserts on the edge that starts A1 after the last POC cycle.
- **Leaving HALT.** The first `clk1` high occurs one clock after the decision.
- **Latency from `step_req` rise to `step_ack`.** This is 2 + 32·SLOT_LEN clocks:
  - 1 clock for edge detect;
  - 1 clock for the HALT decision;
  - then 32·SLOT_LEN clocks for the instruction cycle.
- **`halted`.** Asserts on the edge that enters HALT.

## Test plan

- **Reset and POC.** SLOT_LEN=2, POC_CYCLES=2, `run`=1: release reset.
  - `clk1` is high on ticks 0–1 of each 8-clock subcycle and `clk2` on ticks 4–5.
  - `poc` stays 1 for exactly 128 clocks, then drops.
  - `phase` steps 0x01 → 0x80 every 8 clocks.
- **Halt at boundary.** Drop `run` in the middle of M1.
  - The cycle completes and `halted` goes to 1 after X3.
  - `clk1`/`clk2` stay 0 and `phase`=0x01.
  - `cycle_cnt` is incremented by 1.
- **Single step.** While halted, pulse `step_req` for 3 clocks.
  - Exactly one cycle of 64 clocks runs.
  - `step_ack` is a single pulse 66 clocks after the rise.
  - The block returns to HALT. No second step occurs while `step_req` stays high.
- **Sync re-alignment.** In RUN, drive `sync_in`=1 at the end of M2.
  - `sync_err` pulses for 1 clock.
  - The next `phase` is 0x01.
  - `cycle_cnt` increments.
- **Simultaneous requests.** Assert `poc_req` and a `step_req` edge in the same clock while halted.
  - POC is entered, with `poc`=1 for POC_CYCLES.
  - The step is discarded and `step_ack` never pulses.
- **Counter wrap and asynchronous reset.**
  - Preload `cycle_cnt`=0xFFFF via a forced run: it reads 0x0000 after the next boundary.
  - Assert `rst_n`=0 during `clk2` high: `clk2` falls immediately and all outputs take their reset values.
